mux_sel_sequencer: RTL

- Upstream controller for the 16:1 select mux.
- Accepts a 16-bit word over a valid/ready handshake, holds it on the mux data inputs, and steps the 4-bit select through all 16 positions.
- Returns the mux output as a serial bit stream with its own valid/ready handshake.
- The block plus one external 16:1 mux instance form a parallel-to-serial converter.

---
 rtl/mux_sel_sequencer_pkg.sv | 13 +
 rtl/mux_sel_sequencer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mux_sel_sequencer_pkg.sv
// Shared constants for the 16:1 mux select sequencer: select width,
// FSM state encoding and serialisation direction.
package mux_sel_sequencer_pkg;

   localparam int SEL_W_DEF = 4;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

endpackage : mux_sel_sequencer_pkg

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial controller: holds a loaded word on an external 16:1 mux
// and walks the select through all positions, streaming the mux output.
module mux_sel_sequencer
   import mux_sel_sequencer_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF,
   localparam int N    = 2 ** SEL_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [N-1:0]     load_data,
   input  logic             load_msb_first,
   input  logic             abort,
   output logic [N-1:0]     mux_data,
   output logic [SEL_W-1:0] mux_sel,
   input  logic             mux_out,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_bit,
   output logic             ser_last,
   output logic             busy,
   output logic             done
);

   localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
   localparam logic [SEL_W-1:0] SEL_ONE  = {{(SEL_W-1){1'b0}}, 1'b1};
   localparam logic [SEL_W-1:0] SEL_MAX  = {SEL_W{1'b1}};
   localparam logic [SEL_W-1:0] CNT_PEN  = {{(SEL_W-1){1'b1}}, 1'b0};
   localparam logic [N-1:0]     DATA_ZERO = {N{1'b0}};

   logic             state_r, state_s;
   logic             dir_r, dir_s;
   logic [SEL_W-1:0] cnt_r, cnt_s;
   logic [SEL_W-1:0] sel_r, sel_s;
   logic [N-1:0]     data_r, data_s;
   logic             last_r, last_s;
   logic             done_r, done_s;

   // Select moves towards bit 0 for MSB-first words, towards N-1 otherwise.
   function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] sel,
                                                 input logic             dir);
      if (dir == DIR_MSB) begin
         return sel - SEL_ONE;
      end else begin
         return sel + SEL_ONE;
      end
   endfunction

   // Next-state logic: load in IDLE, step on each beat in SHIFT, abort wins over a beat.
   always_comb begin
      state_s = state_r;
      dir_s   = dir_r;
      cnt_s   = cnt_r;
      sel_s   = sel_r;
      data_s  = data_r;
      last_s  = last_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (load_valid) begin
               state_s = ST_SHIFT;
               data_s  = load_data;
               dir_s   = load_msb_first;
               sel_s   = (load_msb_first == DIR_MSB) ? SEL_MAX : SEL_ZERO;
               cnt_s   = SEL_ZERO;
               last_s  = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_s = ST_IDLE;
               sel_s   = SEL_ZERO;
               cnt_s   = SEL_ZERO;
               last_s  = 1'b0;
            end else if (ser_ready) begin
               if (last_r) begin
                  state_s = ST_IDLE;
                  sel_s   = SEL_ZERO;
                  cnt_s   = SEL_ZERO;
                  last_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  cnt_s  = cnt_r + SEL_ONE;
                  sel_s  = step_sel(sel_r, dir_r);
                  last_s = (cnt_r == CNT_PEN);
               end
            end else begin
               state_s = ST_SHIFT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            sel_s   = SEL_ZERO;
            cnt_s   = SEL_ZERO;
            last_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         dir_r   <= DIR_LSB;
         cnt_r   <= SEL_ZERO;
         sel_r   <= SEL_ZERO;
         data_r  <= DATA_ZERO;
         last_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         dir_r   <= dir_s;
         cnt_r   <= cnt_s;
         sel_r   <= sel_s;
         data_r  <= data_s;
         last_r  <= last_s;
         done_r  <= done_s;
      end
   end

   // Handshake flags decode straight from the state register; ser_bit is the mux itself.
   assign load_ready = (state_r == ST_IDLE);
   assign ser_valid  = (state_r == ST_SHIFT);
   assign busy       = (state_r == ST_SHIFT);
   assign ser_last   = last_r;
   assign done       = done_r;
   assign mux_data   = data_r;
   assign mux_sel    = sel_r;
   assign ser_bit    = mux_out;

endmodule : mux_sel_sequencer
